// File: rtl/load_store_unit_pkg.sv
// Shared MIPS data-memory definitions: opcodes, LSU FSM states and
// access-size/sign helpers used by the load/store unit and its lane logic.
package mips_mem_pkg;

   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_SB  = 6'h28;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SW  = 6'h2B;

   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      RD_ISSUE = 3'd1,
      RD_DATA  = 3'd2,
      WR_ISSUE = 3'd3,
      RESP     = 3'd4
   } lsu_state_e;

   function automatic logic op_known(input logic [5:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU, OP_SB, OP_SH, OP_SW};
   endfunction

   function automatic logic op_is_load(input logic [5:0] op);
      return op inside {OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU};
   endfunction

   function automatic logic op_signed(input logic [5:0] op);
      return op inside {OP_LB, OP_LH};
   endfunction

   function automatic logic [1:0] op_size(input logic [5:0] op);
      logic [1:0] sz;
      case (op)
         OP_LB, OP_LBU, OP_SB: sz = SZ_BYTE;
         OP_LH, OP_LHU, OP_SH: sz = SZ_HALF;
         default:              sz = SZ_WORD;
      endcase
      return sz;
   endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response handshake of the load/store unit.
interface load_store_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [5:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_error;

   modport master (
      output req_valid, req_op, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_error
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_error
   );
endinterface

// File: rtl/load_store_unit_byte_lane.sv
// Little-endian lane logic: extract/extend a load value from a memory word
// and merge sub-word store data into a word for read-modify-write.
module lsu_byte_lane
   import mips_mem_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [5:0]  op,
   input  logic [31:0] wdata,
   output logic [31:0] load_val,
   output logic [31:0] merged
);

   logic [7:0]  byte_v;
   logic [15:0] half_v;
   logic        sgn;

   always_comb begin
      byte_v   = word[{lane, 3'b000} +: 8];
      half_v   = lane[1] ? word[31:16] : word[15:0];
      sgn      = op_signed(op);
      load_val = word;
      merged   = word;
      case (op_size(op))
         SZ_BYTE: begin
            load_val = {{24{sgn & byte_v[7]}}, byte_v};
            merged[{lane, 3'b000} +: 8] = wdata[7:0];
         end
         SZ_HALF: begin
            load_val = {{16{sgn & half_v[15]}}, half_v};
            if (lane[1]) merged[31:16] = wdata[15:0];
            else         merged[15:0]  = wdata[15:0];
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit: one request at a time onto a word-wide memory
// without byte enables; sub-word stores are done as read-modify-write.
module load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic               clk,
   input  logic               rst,
   load_store_unit_if.slave   lsu,
   output logic [31:0]        mem_address,
   output logic               mem_write_enable,
   output logic [31:0]        mem_data_out,
   input  logic [31:0]        mem_data_in
);

   lsu_state_e  state_q, state_d;
   logic [5:0]  op_q, op_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic        req_ready_q, req_ready_d;
   logic        resp_valid_q, resp_valid_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        resp_error_q, resp_error_d;
   logic [31:0] mem_address_q, mem_address_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_data_out_q, mem_data_out_d;

   logic [31:0] load_val, merged;
   logic        req_err;
   logic [1:0]  req_sz;

   lsu_byte_lane u_lane (
      .word     (mem_data_in),
      .lane     (addr_q[1:0]),
      .op       (op_q),
      .wdata    (wdata_q),
      .load_val (load_val),
      .merged   (merged)
   );

   always_comb begin
      req_sz  = op_size(lsu.req_op);
      req_err = !op_known(lsu.req_op)
             || (req_sz == SZ_HALF && lsu.req_addr[0])
             || (req_sz == SZ_WORD && lsu.req_addr[1:0] != 2'b00)
             || ({2'b00, lsu.req_addr[31:2]} >= 32'(MEM_WORDS));
   end

   // Memory outputs are loaded on entry to the issuing state so they come
   // straight from flops during RD_ISSUE / WR_ISSUE.
   always_comb begin
      state_d        = state_q;
      op_d           = op_q;
      addr_d         = addr_q;
      wdata_d        = wdata_q;
      req_ready_d    = 1'b0;
      resp_valid_d   = 1'b0;
      resp_rdata_d   = '0;
      resp_error_d   = 1'b0;
      mem_address_d  = mem_address_q;
      mem_we_d       = 1'b0;
      mem_data_out_d = mem_data_out_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (lsu.req_valid && req_ready_q) begin
               req_ready_d = 1'b0;
               op_d        = lsu.req_op;
               addr_d      = lsu.req_addr;
               wdata_d     = lsu.req_wdata;
               if (req_err) begin
                  state_d      = RESP;
                  resp_valid_d = 1'b1;
                  resp_error_d = 1'b1;
               end else if (lsu.req_op == OP_SW) begin
                  state_d        = WR_ISSUE;
                  mem_address_d  = {2'b00, lsu.req_addr[31:2]};
                  mem_we_d       = 1'b1;
                  mem_data_out_d = lsu.req_wdata;
               end else begin
                  state_d       = RD_ISSUE;
                  mem_address_d = {2'b00, lsu.req_addr[31:2]};
               end
            end
         end
         RD_ISSUE: state_d = RD_DATA;
         RD_DATA: begin
            if (op_is_load(op_q)) begin
               state_d      = RESP;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_val;
            end else begin
               state_d        = WR_ISSUE;
               mem_we_d       = 1'b1;
               mem_data_out_d = merged;
            end
         end
         WR_ISSUE: begin
            state_d      = RESP;
            resp_valid_d = 1'b1;
         end
         RESP: begin
            state_d     = IDLE;
            req_ready_d = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q        <= IDLE;
         op_q           <= '0;
         addr_q         <= '0;
         wdata_q        <= '0;
         req_ready_q    <= 1'b0;
         resp_valid_q   <= 1'b0;
         resp_rdata_q   <= '0;
         resp_error_q   <= 1'b0;
         mem_address_q  <= '0;
         mem_we_q       <= 1'b0;
         mem_data_out_q <= '0;
      end else begin
         state_q        <= state_d;
         op_q           <= op_d;
         addr_q         <= addr_d;
         wdata_q        <= wdata_d;
         req_ready_q    <= req_ready_d;
         resp_valid_q   <= resp_valid_d;
         resp_rdata_q   <= resp_rdata_d;
         resp_error_q   <= resp_error_d;
         mem_address_q  <= mem_address_d;
         mem_we_q       <= mem_we_d;
         mem_data_out_q <= mem_data_out_d;
      end
   end

   assign lsu.req_ready      = req_ready_q;
   assign lsu.resp_valid     = resp_valid_q;
   assign lsu.resp_rdata     = resp_rdata_q;
   assign lsu.resp_error     = resp_error_q;
   assign mem_address        = mem_address_q;
   assign mem_write_enable   = mem_we_q;
   assign mem_data_out       = mem_data_out_q;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator that turns MIPS load/store instructions into accesses on the word-wide data memory port. That port carries a word address, write_enable, data_in and a registered data_out, and has no byte enables.
- Performs word, halfword and byte loads with sign/zero extension.
- Implements sub-word stores as read-modify-write.
- Flags misaligned, out-of-range and unknown accesses without touching memory.
- Serves one request at a time through a valid/ready handshake to the pipeline.

Parameters:
MEM_WORDS, 32, number of 32-bit words in the attached data memory; word indices >= MEM_WORDS are out of range.

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  unit can accept a request
req_op  in  6  MIPS opcode: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B
req_addr  in  32  byte address
req_wdata  in  32  store data; the low byte or halfword is used for SB/SH
resp_valid  out  1  one-cycle completion pulse
resp_rdata  out  32  extended load data; 0 for stores and errors
resp_error  out  1  request was misaligned, out of range or an unknown op
mem_address  out  32  word index = req_addr[31:2], zero-extended
mem_write_enable  out  1  write strobe to memory
mem_data_out  out  32  write data to memory
mem_data_in  in  32  registered read data from memory, valid the cycle after a read is presented

Behaviour:
- Reset: while rst==0 at posedge clk:
  - state goes to IDLE; latched request is discarded.
  - req_ready=0, resp_valid=0, resp_rdata=0, resp_error=0.
  - mem_write_enable=0, mem_address=0, mem_data_out=0.
  - Reset mid read-modify-write aborts before WR_ISSUE, so memory is never partially written.
- Byte order: little-endian; byte lane k = bits [8k+7:8k], k = addr[1:0].
- Registered FSM. Memory outputs are driven only from registers.
- IDLE (req_ready=1): on req_valid&&req_ready, latch op, addr and wdata, then decode:
  - Error if op is unknown, or halfword with addr[0]!=0, or word with addr[1:0]!=0, or addr[31:2] >= MEM_WORDS → RESP, resp_error=1.
  - SW → WR_ISSUE.
  - Any load, SB or SH → RD_ISSUE.
- RD_ISSUE: mem_address = word index, mem_write_enable=0 → RD_DATA.
- RD_DATA: sample mem_data_in.
  - Load: extract the lane(s) and sign-extend (LB/LH) or zero-extend (LBU/LHU) into resp_rdata → RESP.
  - SB/SH: replace the addressed lane(s) of the sampled word with wdata[7:0]/wdata[15:0] into the merge register → WR_ISSUE.
- WR_ISSUE: mem_address = word index, mem_write_enable=1 for exactly this cycle, mem_data_out = wdata (SW) or the merge word → RESP.
- RESP: resp_valid=1 for one cycle with resp_rdata and resp_error → IDLE.
- req_ready=0 in every state except IDLE. There is no resp back-pressure.
- Latency, counted from the accept edge to the resp_valid cycle:
  - error: 1
  - SW: 2
  - loads: 3
  - SB/SH: 4
- mem_write_enable is 0 in every state except WR_ISSUE. Errored requests issue no memory cycle.
- Address wrap: word index MEM_WORDS-1 is legal. Index MEM_WORDS and above is an error; addresses are never truncated or wrapped.
- Requests are accepted back-to-back: a request may be accepted in the IDLE cycle after RESP.

Decomposition:
- Package mips_mem_pkg holds:
  - the opcode localparams (OP_LB…OP_SW),
  - the FSM state enum (IDLE, RD_ISSUE, RD_DATA, WR_ISSUE, RESP),
  - size/sign helper constants.
- One combinational sub-module, lsu_byte_lane, holds the lane extract/extend and merge functions. Inputs: word, addr[1:0], op, wdata. Outputs: load value and merged word.

Test Plan:
1. Reset then SW addr 0x8, wdata 0xDEADBEEF → in cycle 1 after accept mem_write_enable=1, mem_address=2, mem_data_out=0xDEADBEEF; resp_valid at cycle 2 with resp_error=0.
2. After test 1:
   - LB addr 0x9 → resp_rdata 0xFFFFFFBE at cycle 3.
   - LBU addr 0x9 → 0x000000BE.
   - LH addr 0xA → 0xFFFFDEAD.
   - LHU addr 0xA → 0x0000DEAD.
3. After test 1:
   - SB addr 0xB, wdata 0x12 → read at cycle 1, write of 0x12ADBEEF at cycle 3, resp at cycle 4.
   - Then SH addr 0x8, wdata 0x5678 → write of 0x12AD5678.
4. Errors, each giving resp_error=1, resp_rdata=0, resp at cycle 1 and no mem_write_enable:
   - LW addr 0x6
   - SH addr 0x3
   - LW addr 0x80 (word 32 with MEM_WORDS=32)
   - op 0x3F
5. LW addr 0x7C (word 31) → legal; returns the stored value.
6. Abort and handshake:
   - Drive rst=0 during RD_DATA of an SB → no write occurs, outputs zero, req_ready=1 in the cycle after rst releases.
   - req_valid held high continuously → req_ready is seen only in IDLE cycles, and every request completes exactly once.
